// File: rtl/merge_stream_core.sv
// merge_stream_core: merges two ascending-sorted streams (A, B) into one
// ascending stream of len_a+len_b beats through a single registered output
// stage. Ties go to A, so equal keys keep A-before-B order.
// Optional build macro: MERGE_ORDER_CHECK_EN adds a sticky order_err flag
// raised when either input stream steps downwards.
module merge_stream_core #(
    parameter int DATA_W = 32,
    parameter int LEN_W  = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [LEN_W-1:0]  len_a,
    input  logic [LEN_W-1:0]  len_b,
    output logic              busy,
    output logic              done,
    output logic [LEN_W:0]    out_count,
    output logic              order_err,
    input  logic [DATA_W-1:0] a_data,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [DATA_W-1:0] b_data,
    input  logic              b_valid,
    output logic              b_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MERGE,
        S_DRAIN_A,
        S_DRAIN_B,
        S_FLUSH
    } state_t;

    localparam logic [LEN_W-1:0] REM_ONE = LEN_W'(1);
    localparam logic [LEN_W:0]   CNT_ONE = (LEN_W+1)'(1);

    state_t           state;
    logic [LEN_W-1:0] rem_a;
    logic [LEN_W-1:0] rem_b;
    logic             ld;
    logic             a_fire;
    logic             b_fire;

    // Ready generation: only the stream chosen this cycle sees ld, and only
    // while the merge is active so surplus input beats are never taken.
    always_comb begin
        ld      = !m_valid || m_ready;
        a_ready = 1'b0;
        b_ready = 1'b0;
        case (state)
            S_MERGE: begin
                if (a_valid && b_valid) begin
                    if (a_data <= b_data) a_ready = ld;
                    else                  b_ready = ld;
                end
            end
            S_DRAIN_A: a_ready = ld;
            S_DRAIN_B: b_ready = ld;
            default: ;
        endcase
        a_fire = a_valid && a_ready;
        b_fire = b_valid && b_ready;
    end

    // Control FSM, remaining-count tracking and the registered output stage.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_IDLE;
            rem_a     <= '0;
            rem_b     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            out_count <= '0;
            m_data    <= '0;
            m_valid   <= 1'b0;
            m_last    <= 1'b0;
        end else begin
            done <= 1'b0;

            if (m_valid && m_ready && out_count != '1)
                out_count <= out_count + CNT_ONE;

            // Output register: load the selected beat, or empty on ld.
            if (ld) begin
                if (a_fire) begin
                    m_data  <= a_data;
                    m_valid <= 1'b1;
                    m_last  <= (rem_a == REM_ONE) && (rem_b == '0);
                end else if (b_fire) begin
                    m_data  <= b_data;
                    m_valid <= 1'b1;
                    m_last  <= (rem_b == REM_ONE) && (rem_a == '0);
                end else begin
                    m_valid <= 1'b0;
                    m_last  <= 1'b0;
                end
            end

            if (a_fire) rem_a <= rem_a - REM_ONE;
            if (b_fire) rem_b <= rem_b - REM_ONE;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        rem_a     <= len_a;
                        rem_b     <= len_b;
                        out_count <= '0;
                        busy      <= 1'b1;
                        if (len_a == '0 && len_b == '0) state <= S_FLUSH;
                        else if (len_b == '0)           state <= S_DRAIN_A;
                        else if (len_a == '0)           state <= S_DRAIN_B;
                        else                            state <= S_MERGE;
                    end
                end
                S_MERGE: begin
                    if (a_fire && rem_a == REM_ONE)      state <= S_DRAIN_B;
                    else if (b_fire && rem_b == REM_ONE) state <= S_DRAIN_A;
                end
                S_DRAIN_A: begin
                    if (a_fire && rem_a == REM_ONE) state <= S_FLUSH;
                end
                S_DRAIN_B: begin
                    if (b_fire && rem_b == REM_ONE) state <= S_FLUSH;
                end
                S_FLUSH: begin
                    // Final beat is either leaving now or was never loaded.
                    if (!m_valid || m_ready) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef MERGE_ORDER_CHECK_EN
    logic [DATA_W-1:0] prev_a;
    logic [DATA_W-1:0] prev_b;
    logic              seen_a;
    logic              seen_b;

    // Flag any accepted beat that is below its predecessor on the same stream.
    always_ff @(posedge clock) begin
        if (reset) begin
            prev_a    <= '0;
            prev_b    <= '0;
            seen_a    <= 1'b0;
            seen_b    <= 1'b0;
            order_err <= 1'b0;
        end else if (state == S_IDLE && start) begin
            seen_a    <= 1'b0;
            seen_b    <= 1'b0;
            order_err <= 1'b0;
        end else begin
            if (a_fire) begin
                if (seen_a && a_data < prev_a) order_err <= 1'b1;
                prev_a <= a_data;
                seen_a <= 1'b1;
            end
            if (b_fire) begin
                if (seen_b && b_data < prev_b) order_err <= 1'b1;
                prev_b <= b_data;
                seen_b <= 1'b1;
            end
        end
    end
`else
    assign order_err = 1'b0;
`endif

endmodule

// File: tb/tb_merge_stream_core.sv
// Scoreboard bench for merge_stream_core: directed scenarios plus randomized
// merges; a reference merge fills the expected queue, a monitor drains it.
module tb_merge_stream_core;

    localparam int DW = 32;
    localparam int LW = 8;
`ifdef MERGE_ORDER_CHECK_EN
    localparam bit ORD_EN = 1'b1;
`else
    localparam bit ORD_EN = 1'b0;
`endif

    typedef struct packed {
        logic [DW-1:0] d;
        logic          l;
    } beat_t;

    logic          clock, reset, start;
    logic [LW-1:0] len_a, len_b;
    logic          busy, done, order_err;
    logic [LW:0]   out_count;
    logic [DW-1:0] a_data, b_data, m_data;
    logic          a_valid, a_ready, b_valid, b_ready;
    logic          m_valid, m_ready, m_last;

    beat_t         exp_q[$];
    logic [DW-1:0] a_src[$];
    logic [DW-1:0] b_src[$];
    int            checks = 0;
    int            errors = 0;
    bit            drv_en, rand_vld;
    int            rdy_mode, b_hs, mon_beats;

    merge_stream_core #(.DATA_W(DW), .LEN_W(LW)) dut (
        .clock(clock), .reset(reset), .start(start),
        .len_a(len_a), .len_b(len_b),
        .busy(busy), .done(done), .out_count(out_count), .order_err(order_err),
        .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready),
        .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    // Reference merge: two-pointer over the first la/lb source entries.
    task automatic model(input int la, input int lb);
        int i = 0;
        int j = 0;
        beat_t e;
        while (i < la || j < lb) begin
            if (i < la && (j >= lb || a_src[i] <= b_src[j])) begin
                e.d = a_src[i]; i++;
            end else begin
                e.d = b_src[j]; j++;
            end
            e.l = (i + j == la + lb);
            exp_q.push_back(e);
        end
    endtask

    // Stream drivers: advance sources on observed handshakes, drive m_ready.
    initial begin : drv
        bit fa, fb;
        a_valid = 0; b_valid = 0; a_data = '0; b_data = '0; m_ready = 1'b0;
        forever begin
            @(negedge clock);
            fa = a_valid && a_ready;
            fb = b_valid && b_ready;
            @(posedge clock);
            #1;
            if (fa && a_src.size() > 0) void'(a_src.pop_front());
            if (fb && b_src.size() > 0) begin void'(b_src.pop_front()); b_hs++; end
            a_valid = drv_en && (a_src.size() > 0) && (!rand_vld || $urandom_range(3) != 0);
            b_valid = drv_en && (b_src.size() > 0) && (!rand_vld || $urandom_range(3) != 0);
            a_data  = (a_src.size() > 0) ? a_src[0] : '0;
            b_data  = (b_src.size() > 0) ? b_src[0] : '0;
            case (rdy_mode)
                0:       m_ready = 1'b1;
                1:       m_ready = ~m_ready;
                default: m_ready = ($urandom_range(1) == 1);
            endcase
        end
    end

    // Monitor: compare every output transfer, stall stability and done timing.
    initial begin : mon
        bit            ps, cd;
        logic [DW-1:0] pd;
        logic          pl;
        beat_t         e;
        ps = 0; cd = 0; pd = '0; pl = 0;
        forever begin
            @(negedge clock);
            if (reset) begin
                ps = 0; cd = 0;
            end else begin
                if (cd) begin check("done_after_last", 64'(done), 64'(1)); cd = 0; end
                if (ps) begin
                    check("stall_valid", 64'(m_valid), 64'(1));
                    check("stall_data", 64'(m_data), 64'(pd));
                    check("stall_last", 64'(m_last), 64'(pl));
                end
                ps = m_valid && !m_ready; pd = m_data; pl = m_last;
                if (m_valid && m_ready) begin
                    mon_beats++;
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_beat: got %0h expected none", m_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("m_data", 64'(m_data), 64'(e.d));
                        check("m_last", 64'(m_last), 64'(e.l));
                        if (m_last) cd = 1;
                    end
                end
            end
        end
    end

    task automatic prep();
        drv_en = 0;
        @(posedge clock);
        #2;
        a_src.delete(); b_src.delete(); exp_q.delete();
        b_hs = 0; mon_beats = 0;
    endtask

    task automatic do_start(input int la, input int lb);
        @(posedge clock); #1;
        len_a = LW'(la); len_b = LW'(lb); start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    task automatic run_merge(input int la, input int lb, input int mode, input bit rv, input bit eo);
        int cyc;
        rdy_mode = mode; rand_vld = rv;
        model(la, lb);
        drv_en = 1;
        do_start(la, lb);
        @(negedge clock);
        check("busy_after_start", 64'(busy), 64'(1));
        cyc = 1;
        while (!done && cyc < 4000) begin @(negedge clock); cyc++; end
        check("done_seen", 64'(done), 64'(1));
        if (la + lb == 0) check("zero_len_done_lat", 64'(cyc <= 2), 64'(1));
        check("busy_at_done", 64'(busy), 64'(0));
        check("out_count", 64'(out_count), 64'(la + lb));
        check("exp_drained", 64'(exp_q.size()), 64'(0));
        check("order_err", 64'(order_err), 64'(eo));
        @(negedge clock);
        check("done_one_cycle", 64'(done), 64'(0));
    endtask

    task automatic load_t1();
        a_src = '{32'd1, 32'd4, 32'd9};
        b_src = '{32'd2, 32'd4, 32'd10};
    endtask

    initial begin : main
        int cyc, la, lb, xa, xb;
        logic [DW-1:0] v;
        reset = 1; start = 0; len_a = '0; len_b = '0;
        drv_en = 0; rand_vld = 0; rdy_mode = 0; b_hs = 0; mon_beats = 0;
        repeat (3) @(posedge clock);
        #1 reset = 0;
        @(negedge clock);
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_m_valid", 64'(m_valid), 64'(0));
        check("rst_m_last", 64'(m_last), 64'(0));
        check("rst_m_data", 64'(m_data), 64'(0));
        check("rst_out_count", 64'(out_count), 64'(0));
        check("rst_order_err", 64'(order_err), 64'(0));

        // Basic merge with a tie
        prep(); load_t1(); run_merge(3, 3, 0, 0, 0);
        // Zero-length merge
        prep(); run_merge(0, 0, 0, 0, 0);
        // B exhausted first; surplus B beat must stay unconsumed
        prep();
        a_src = '{32'd5, 32'd6, 32'd7, 32'd8};
        b_src = '{32'd1, 32'd77};
        run_merge(4, 1, 0, 0, 0);
        check("b_handshakes", 64'(b_hs), 64'(1));
        check("b_surplus_left", 64'(b_src.size()), 64'(1));
        // Toggling m_ready
        prep(); load_t1(); run_merge(3, 3, 1, 0, 0);

        // Reset mid-merge, then a fresh merge
        prep();
        a_src = '{32'd1, 32'd3, 32'd5, 32'd7};
        b_src = '{32'd2, 32'd4, 32'd6, 32'd8};
        rdy_mode = 0; rand_vld = 0;
        model(4, 4);
        drv_en = 1;
        do_start(4, 4);
        cyc = 0;
        while (mon_beats < 2 && cyc < 200) begin @(negedge clock); cyc++; end
        check("two_beats_before_reset", 64'(mon_beats >= 2), 64'(1));
        @(posedge clock); #1;
        reset = 1; drv_en = 0;
        @(posedge clock); #1;
        reset = 0;
        @(negedge clock);
        check("mid_rst_busy", 64'(busy), 64'(0));
        check("mid_rst_m_valid", 64'(m_valid), 64'(0));
        check("mid_rst_m_last", 64'(m_last), 64'(0));
        check("mid_rst_m_data", 64'(m_data), 64'(0));
        check("mid_rst_out_count", 64'(out_count), 64'(0));
        check("mid_rst_a_ready", 64'(a_ready), 64'(0));
        check("mid_rst_b_ready", 64'(b_ready), 64'(0));
        exp_q.delete();
        prep(); load_t1(); run_merge(3, 3, 2, 1, 0);

        // Descending A stream: merge continues, order_err depends on build
        prep();
        a_src = '{32'd3, 32'd2};
        b_src = '{32'd5};
        run_merge(2, 1, 0, 0, ORD_EN);
        prep(); load_t1(); run_merge(3, 3, 0, 0, 0);

        // Randomized merges, including unsigned-top values and surplus beats
        for (int it = 0; it < 24; it++) begin
            prep();
            la = $urandom_range(12); lb = $urandom_range(12);
            if ($urandom_range(4) == 0) la = 0;
            if ($urandom_range(4) == 0) lb = 0;
            v = ($urandom_range(3) == 0) ? 32'hFFFF_FF00 : DW'($urandom_range(20));
            for (int k = 0; k < la; k++) begin a_src.push_back(v); v = v + DW'($urandom_range(3)); end
            v = ($urandom_range(3) == 0) ? 32'hFFFF_FF00 : DW'($urandom_range(20));
            for (int k = 0; k < lb; k++) begin b_src.push_back(v); v = v + DW'($urandom_range(3)); end
            xa = int'($urandom_range(1)); xb = int'($urandom_range(1));
            if (xa == 1) a_src.push_back(32'd0);
            if (xb == 1) b_src.push_back(32'd0);
            run_merge(la, lb, int'($urandom_range(2)), 1, 0);
            check("rand_a_surplus", 64'(a_src.size()), 64'(xa));
            check("rand_b_surplus", 64'(b_src.size()), 64'(xb));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/merge_stream_core.md
Name: merge_stream_core

Overview:
- Merge datapath that sits directly downstream of the mege_ip AXI4-Lite register slave.
- The slave's registers supply start, len_a and len_b; the slave reads back busy, done, out_count and order_err.
- The block consumes two ascending-sorted input streams (A, B) and emits one ascending-sorted stream of len_a+len_b beats.
- It uses a registered single-entry output stage with valid/ready handshakes on every stream.

Parameters:
DATA_W, 32, element width; compare is unsigned
LEN_W, 8, width of each length field; max elements per array = 2^LEN_W-1

Ports:
clock  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
start  in  1  single-cycle pulse that launches a merge; sampled only in IDLE
len_a  in  LEN_W  number of A elements; latched on accepted start
len_b  in  LEN_W  number of B elements; latched on accepted start
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse after the last output beat is accepted
out_count  out  LEN_W+1  output beats accepted since the last start
order_err  out  1  sticky input-order error flag (see Optional Feature)
a_data  in  DATA_W  A stream data
a_valid  in  1  A stream valid
a_ready  out  1  A stream ready
b_data  in  DATA_W  B stream data
b_valid  in  1  B stream valid
b_ready  out  1  B stream ready
m_data  out  DATA_W  merged output data
m_valid  out  1  merged output valid
m_ready  in  1  downstream ready
m_last  out  1  high with the final output beat

Behaviour:
- Reset (one clock edge with reset=1): state=IDLE. busy, done, m_valid, m_last, a_ready, b_ready, order_err = 0. out_count = 0. Remaining counters = 0. m_data = 0.
- Reset asserted mid-merge aborts immediately. No done pulse is issued. Partially consumed input is discarded.
- Output register load enable: ld = !m_valid || m_ready.
- On ld with no new selection, m_valid clears.
- Transfer rules:
  - Input transfer: x_valid && x_ready.
  - Output transfer: m_valid && m_ready.
  - m_data and m_last are held stable while m_valid && !m_ready.
- State IDLE:
  - start=1 latches rem_a=len_a, rem_b=len_b and clears out_count and order_err.
  - Next state:
    - both lengths 0 -> FLUSH
    - only rem_b=0 -> DRAIN_A
    - only rem_a=0 -> DRAIN_B
    - otherwise -> MERGE
  - start in any other state is ignored.
- State MERGE:
  - Waits for a_valid && b_valid. Never selects on a single valid input.
  - Selection: A if a_data <= b_data (tie -> A, stable), else B.
  - Only the selected ready is driven (= ld). The other ready = 0.
  - The selected beat loads the output register, and its rem counter decrements.
  - Goes to DRAIN_B when rem_a hits 0, or to DRAIN_A when rem_b hits 0.
- State DRAIN_A: a_ready = ld. Passes A beats through until rem_a=0. b_ready = 0.
- State DRAIN_B: mirror of DRAIN_A for the B stream.
- m_last is set on the load of the beat that makes rem_a+rem_b = 0.
- State FLUSH:
  - Waits for the final output transfer.
  - For a zero-length merge, skips the wait.
  - Then pulses done for 1 cycle and returns to IDLE.
- Latency:
  - Selected beat appears on m_data the cycle after its input transfer.
  - Sustained throughput is 1 beat/cycle when m_ready=1.
- out_count increments on each output transfer and saturates at 2^(LEN_W+1)-1.
- Ready signals are combinational from state, valids and ld. No combinational path from m_ready to m_valid.
- Extra input beats beyond the latched lengths are never accepted: a_ready/b_ready = 0 outside the active states.

Optional Feature:
- Macro: MERGE_ORDER_CHECK_EN.
- Defined:
  - The block keeps the last accepted value per stream.
  - Any accepted A (or B) beat smaller than the previous beat from the same stream sets order_err.
  - order_err stays set until the next accepted start or reset.
  - The merge continues regardless.
- Undefined: order_err is tied to 0 and the tracking registers are not built.

Test Plan:
- len_a=3 A={1,4,9}, len_b=3 B={2,4,10}, m_ready=1 -> m_data 1,2,4(A),4(B),9,10; m_last on 10; done 1 cycle later; out_count=6.
- len_a=0, len_b=0, start -> no m_valid; done pulses within 2 cycles; busy low afterwards.
- len_a=4 A={5,6,7,8}, len_b=1 B={1} -> output 1,5,6,7,8; B stream sees exactly 1 ready handshake.
- Same as the first scenario, with m_ready toggling 1/0 every cycle -> m_data/m_last stable while stalled; identical output sequence; no dropped or duplicated beats.
- Reset asserted after 2 output beats -> all outputs reach reset values next cycle; a new start completes a full merge correctly.
- MERGE_ORDER_CHECK_EN defined, A={3,2}, B={5} -> order_err=1 after the second A beat; output 3,2,5; next start clears order_err.
